// File: rtl/rfsp_fifo_ctrl.sv
// Valid/ready FIFO on a single-port register-file macro: one SRAM access per cycle,
// alternating write/prefetch-read grant, 2-entry output buffer hiding read latency.
module rfsp_fifo_ctrl #(
  parameter int         WORDSWD  = 7,
  parameter int         BITS     = 128,
  parameter logic [2:0] EMA_VAL  = 3'b010,
  parameter logic [1:0] EMAW_VAL = 2'b00
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [BITS-1:0]    in_data,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [BITS-1:0]    out_data,
  output logic [WORDSWD+1:0] count,
  output logic               SRAM_CEN,
  output logic               SRAM_GWEN,
  output logic [BITS-1:0]    SRAM_WEN,
  output logic [WORDSWD-1:0] SRAM_A,
  output logic [BITS-1:0]    SRAM_D,
  input  logic [BITS-1:0]    SRAM_Q,
  output logic [2:0]         SRAM_EMA,
  output logic [1:0]         SRAM_EMAW,
  output logic               SRAM_RET1N
);

  localparam logic [WORDSWD:0] DEPTH = {1'b1, {WORDSWD{1'b0}}};

  logic [WORDSWD-1:0] r_wr_ptr;
  logic [WORDSWD-1:0] r_rd_ptr;
  logic [WORDSWD:0]   r_sram_cnt;
  logic               r_rd_inflight;
  logic [1:0]         r_buf_cnt;
  logic [BITS-1:0]    r_buf0;
  logic [BITS-1:0]    r_buf1;
  logic               r_last_rd;

  logic               w_full;
  logic               w_rd_want;
  logic               w_rd_sel;
  logic               w_wr_sel;
  logic               w_pop;
  logic [1:0]         w_buf_cnt_nxt;
  logic [BITS-1:0]    w_buf0_nxt;
  logic [BITS-1:0]    w_buf1_nxt;

  assign w_full    = (r_sram_cnt == DEPTH);
  assign w_rd_want = (r_sram_cnt != '0) &&
                     (({1'b0, r_buf_cnt} + {2'b00, r_rd_inflight}) < 3'd2);
  // Grant is held off during reset so the macro sees no access while RSTN is low.
  assign w_rd_sel  = RSTN && w_rd_want && !(r_last_rd && in_vld && !w_full);
  assign in_rdy    = RSTN && !w_full && !w_rd_sel;
  assign w_wr_sel  = in_vld && in_rdy;

  assign SRAM_CEN   = !(w_wr_sel || w_rd_sel);
  assign SRAM_GWEN  = !w_wr_sel;
  assign SRAM_WEN   = {BITS{!w_wr_sel}};
  assign SRAM_A     = w_wr_sel ? r_wr_ptr : r_rd_ptr;
  assign SRAM_D     = in_data;
  assign SRAM_EMA   = EMA_VAL;
  assign SRAM_EMAW  = EMAW_VAL;
  assign SRAM_RET1N = 1'b1;

  assign out_vld  = (r_buf_cnt != 2'd0);
  assign out_data = r_buf0;
  assign w_pop    = out_vld && out_rdy;
  assign count    = {1'b0, r_sram_cnt} + {{(WORDSWD+1){1'b0}}, r_rd_inflight}
                  + {{WORDSWD{1'b0}}, r_buf_cnt};

  // Pop shifts first, so a same-cycle capture lands in the slot just freed.
  always_comb begin
    w_buf0_nxt    = r_buf0;
    w_buf1_nxt    = r_buf1;
    w_buf_cnt_nxt = r_buf_cnt;
    if (w_pop) begin
      w_buf0_nxt    = r_buf1;
      w_buf_cnt_nxt = r_buf_cnt - 2'd1;
    end
    if (r_rd_inflight) begin
      if (w_buf_cnt_nxt == 2'd0) w_buf0_nxt = SRAM_Q;
      else                       w_buf1_nxt = SRAM_Q;
      w_buf_cnt_nxt = w_buf_cnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_sram_cnt    <= '0;
      r_rd_inflight <= 1'b0;
      r_buf_cnt     <= 2'd0;
      r_buf0        <= '0;
      r_buf1        <= '0;
      r_last_rd     <= 1'b0;
    end else begin
      if (w_wr_sel) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_sram_cnt <= r_sram_cnt + 1'b1;
      end else if (w_rd_sel) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_sram_cnt <= r_sram_cnt - 1'b1;
      end
      if (w_wr_sel || w_rd_sel) r_last_rd <= w_rd_sel;
      r_rd_inflight <= w_rd_sel;
      r_buf_cnt     <= w_buf_cnt_nxt;
      r_buf0        <= w_buf0_nxt;
      r_buf1        <= w_buf1_nxt;
    end
  end

endmodule

// File: tb/tb_rfsp_fifo_ctrl.sv
// Bench for rfsp_fifo_ctrl: behavioural single-port SRAM with occupancy tracking,
// a cycle table from reset, then scoreboarded fill/contention/wrap/reset sequences.
module tb_rfsp_fifo_ctrl;
  localparam int W = 7;
  localparam int B = 128;

  logic           CLK = 1'b0;
  logic           RSTN = 1'b0;
  logic           in_vld = 1'b0;
  logic           in_rdy;
  logic [B-1:0]   in_data = '0;
  logic           out_vld;
  logic           out_rdy = 1'b0;
  logic [B-1:0]   out_data;
  logic [W+1:0]   count;
  logic           SRAM_CEN, SRAM_GWEN, SRAM_RET1N;
  logic [B-1:0]   SRAM_WEN, SRAM_D, SRAM_Q;
  logic [W-1:0]   SRAM_A;
  logic [2:0]     SRAM_EMA;
  logic [1:0]     SRAM_EMAW;

  rfsp_fifo_ctrl #(.WORDSWD(W), .BITS(B), .EMA_VAL(3'b010), .EMAW_VAL(2'b00)) dut (
    .CLK(CLK), .RSTN(RSTN), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .count(count),
    .SRAM_CEN(SRAM_CEN), .SRAM_GWEN(SRAM_GWEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A),
    .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q), .SRAM_EMA(SRAM_EMA), .SRAM_EMAW(SRAM_EMAW),
    .SRAM_RET1N(SRAM_RET1N));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input bit ok, input string name, input logic [B-1:0] act,
                     input logic [B-1:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // SRAM model: one-cycle read latency, and a per-address "unread" flag that
  // catches overwrite-while-full and read-of-empty.
  logic [B-1:0] mem [1<<W];
  logic [(1<<W)-1:0] valid;
  logic [B-1:0] r_q = '0;
  logic [W-1:0] last_wa = '0;
  int wraps = 0;
  assign SRAM_Q = r_q;

  always @(posedge CLK) begin
    if (!RSTN) begin
      valid <= '0;
    end else if (!SRAM_CEN) begin
      if (!SRAM_GWEN) begin
        chk(!valid[SRAM_A], "sram_overwrite", B'(SRAM_A), '0);
        chk(SRAM_WEN == '0, "sram_wen_wr", SRAM_WEN, '0);
        mem[SRAM_A]   <= SRAM_D;
        valid[SRAM_A] <= 1'b1;
        if (SRAM_A == '0 && last_wa == W'((1<<W)-1)) wraps <= wraps + 1;
        last_wa <= SRAM_A;
      end else begin
        chk(valid[SRAM_A], "sram_underflow", B'(SRAM_A), '0);
        chk(SRAM_WEN == '1, "sram_wen_rd", SRAM_WEN, '1);
        r_q           <= mem[SRAM_A];
        valid[SRAM_A] <= 1'b0;
      end
    end
  end

  logic [B-1:0] sbq [$];
  int held = 0;
  int next_word = 0;
  logic s_cen, s_gwen;

  function automatic logic [B-1:0] word_val(input int k);
    return {32'(k) ^ 32'hA5A5_0000, ~32'(k), 32'hC3C3_0000 + 32'(k), 32'(k)};
  endfunction

  // One cycle with scoreboard; entered and left at the falling edge.
  task automatic tick(input logic v, input logic r);
    logic [B-1:0] e;
    in_vld = v; in_data = word_val(next_word); out_rdy = r;
    #1;
    s_cen = SRAM_CEN; s_gwen = SRAM_GWEN;
    chk(count == (W+2)'(held), "count", B'(count), B'(held));
    if (out_vld && out_rdy) begin
      chk(sbq.size() != 0, "pop_nonempty", B'(sbq.size()), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk(out_data == e, "pop_data", out_data, e);
      end
      held--;
    end
    if (in_vld && in_rdy) begin
      sbq.push_back(in_data);
      next_word++;
      held++;
    end
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic stream(input int n_push, input int vld_pct, input int rdy_pct,
                        input bit drain, input int max_cyc);
    int start = next_word;
    logic v, r;
    for (int c = 0; c < max_cyc; c++) begin
      if ((next_word - start) >= n_push && (!drain || held == 0)) break;
      v = ((next_word - start) < n_push) && ($urandom_range(99) < vld_pct);
      r = ($urandom_range(99) < rdy_pct);
      tick(v, r);
    end
    chk((next_word - start) >= n_push && (!drain || held == 0), "stream_timeout",
        B'(next_word - start), B'(n_push));
    in_vld = 1'b0; out_rdy = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'($urandom); out_rdy = 1'($urandom); in_data = {4{$urandom}};
      #1;
      chk(out_vld == 1'b0, "rst_out_vld", B'(out_vld), 0);
      chk(count == '0, "rst_count", B'(count), 0);
      chk(SRAM_CEN == 1'b1, "rst_cen", B'(SRAM_CEN), 1);
      chk(SRAM_GWEN == 1'b1, "rst_gwen", B'(SRAM_GWEN), 1);
      chk(SRAM_WEN == '1, "rst_wen", SRAM_WEN, '1);
      @(posedge CLK); @(negedge CLK);
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    RSTN = 1'b1;
    sbq.delete(); held = 0;
    #1;
    chk(in_rdy == 1'b1, "rst_release_in_rdy", B'(in_rdy), 1);
  endtask

  typedef struct packed {
    logic         vld;
    logic [B-1:0] d;
    logic         rdy;
    logic         e_in_rdy;
    logic         e_out_vld;
    logic [B-1:0] e_out_data;
    logic [W+1:0] e_count;
    logic         e_cen;
    logic         e_gwen;
    logic [W-1:0] e_a;
  } vec_t;

  vec_t vt [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            vld  data     rdy  in_rdy ovld  odata    cnt  cen  gwen A
    vt[0] = '{1'b1, 128'hA5, 1'b1, 1'b1, 1'b0, 128'h0,  9'd0, 1'b0, 1'b0, 7'd0};
    vt[1] = '{1'b1, 128'hB6, 1'b1, 1'b0, 1'b0, 128'h0,  9'd1, 1'b0, 1'b1, 7'd0};
    vt[2] = '{1'b1, 128'hB6, 1'b1, 1'b1, 1'b0, 128'h0,  9'd1, 1'b0, 1'b0, 7'd1};
    vt[3] = '{1'b0, 128'h0,  1'b0, 1'b0, 1'b1, 128'hA5, 9'd2, 1'b0, 1'b1, 7'd1};
    vt[4] = '{1'b0, 128'h0,  1'b1, 1'b1, 1'b1, 128'hA5, 9'd2, 1'b1, 1'b1, 7'd2};
    vt[5] = '{1'b0, 128'h0,  1'b1, 1'b1, 1'b1, 128'hB6, 9'd1, 1'b1, 1'b1, 7'd2};
    vt[6] = '{1'b0, 128'h0,  1'b0, 1'b1, 1'b0, 128'h0,  9'd0, 1'b1, 1'b1, 7'd2};

    @(negedge CLK);
    do_reset();
    chk(SRAM_EMA == 3'b010, "ema", B'(SRAM_EMA), 2);
    chk(SRAM_EMAW == 2'b00, "emaw", B'(SRAM_EMAW), 0);
    chk(SRAM_RET1N == 1'b1, "ret1n", B'(SRAM_RET1N), 1);

    // Single-word cycle table from reset
    for (int i = 0; i < 7; i++) begin
      in_vld = vt[i].vld; in_data = vt[i].d; out_rdy = vt[i].rdy;
      #1;
      chk(in_rdy == vt[i].e_in_rdy, $sformatf("vec%0d_in_rdy", i), B'(in_rdy), B'(vt[i].e_in_rdy));
      chk(out_vld == vt[i].e_out_vld, $sformatf("vec%0d_out_vld", i), B'(out_vld), B'(vt[i].e_out_vld));
      if (vt[i].e_out_vld)
        chk(out_data == vt[i].e_out_data, $sformatf("vec%0d_out_data", i), out_data, vt[i].e_out_data);
      chk(count == vt[i].e_count, $sformatf("vec%0d_count", i), B'(count), B'(vt[i].e_count));
      chk(SRAM_CEN == vt[i].e_cen, $sformatf("vec%0d_cen", i), B'(SRAM_CEN), B'(vt[i].e_cen));
      chk(SRAM_GWEN == vt[i].e_gwen, $sformatf("vec%0d_gwen", i), B'(SRAM_GWEN), B'(vt[i].e_gwen));
      chk(SRAM_A == vt[i].e_a, $sformatf("vec%0d_addr", i), B'(SRAM_A), B'(vt[i].e_a));
      @(posedge CLK); @(negedge CLK);
    end
    in_vld = 1'b0; out_rdy = 1'b0;

    // Fill to the stall point with the consumer blocked, then drain in order
    do_reset();
    stream(130, 100, 0, 0, 400);
    in_vld = 1'b1; in_data = word_val(next_word); out_rdy = 1'b0;
    #1;
    chk(in_rdy == 1'b0, "fill_stall_in_rdy", B'(in_rdy), 0);
    chk(count == 9'd130, "fill_stall_count", B'(count), 130);
    chk(out_vld == 1'b1, "fill_head_vld", B'(out_vld), 1);
    chk(out_data == word_val(0), "fill_head_data", out_data, word_val(0));
    @(posedge CLK); @(negedge CLK);
    tick(1'b1, 1'b0);
    stream(2, 100, 100, 1, 600);

    // Contention: both sides busy every cycle, grants must alternate W,R,...
    do_reset();
    stream(10, 100, 0, 0, 100);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      tick(1'b1, 1'b1);
      chk(s_cen == 1'b0, $sformatf("contention_cen%0d", c), B'(s_cen), 0);
      chk(s_gwen == 1'(c % 2), $sformatf("contention_op%0d", c), B'(s_gwen), B'(c % 2));
    end
    stream(0, 0, 100, 1, 100);

    // Random backpressure long enough to wrap the pointers twice
    do_reset();
    wraps = 0;
    stream(300, 70, 60, 1, 3000);
    chk(wraps >= 2, "wrap_count", B'(wraps), 2);

    // Reset while a read is in flight: the returning word must be dropped
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    RSTN = 1'b0;
    #1;
    chk(count == '0, "midrst_count", B'(count), 0);
    chk(out_vld == 1'b0, "midrst_out_vld", B'(out_vld), 0);
    @(posedge CLK); @(negedge CLK);
    RSTN = 1'b1;
    sbq.delete(); held = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      chk(out_vld == 1'b0, $sformatf("midrst_after_vld%0d", i), B'(out_vld), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
